// File: rtl/pe_dualmode_sat.sv
// Systolic MAC processing element with runtime-selectable dataflow.
// WS_RUN: the stationary weight sits in active_w; a shadow weight is shift-loaded
//         down the column while computing and swapped in on w_swap.
// OS_RUN: the accumulator integrates act*weight pairs; drain emits it south and
//         then turns the south psum port into a one-cycle pass-through.
// All east/south outputs are registered, so every hop costs exactly one cycle.
module pe_dualmode_sat #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int SAT     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic               cfg_mode,
  input  logic               halt,
  input  logic               drain,
  input  logic               w_swap,
  input  logic [BW-1:0]      in_w_act,
  input  logic               in_w_valid,
  input  logic [BW-1:0]      in_n_w,
  input  logic               in_n_w_valid,
  input  logic [PSUM_BW-1:0] in_n_psum,
  input  logic               in_n_psum_valid,
  output logic [BW-1:0]      out_e_act,
  output logic               out_e_valid,
  output logic [BW-1:0]      out_s_w,
  output logic               out_s_w_valid,
  output logic [PSUM_BW-1:0] out_s_psum,
  output logic               out_s_psum_valid,
  output logic [1:0]         state,
  output logic               sat_flag
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WS_RUN   = 2'd1,
    OS_RUN   = 2'd2,
    OS_DRAIN = 2'd3
  } state_t;

  // One guard bit above PSUM_BW: a sum of two in-range values (or an in-range
  // value plus a product, which always fits PSUM_BW) never overflows XW bits.
  localparam int XW = PSUM_BW + 1;

  localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [BW-1:0]      shadow_w;
  logic signed [BW-1:0]      active_w;
  logic signed [PSUM_BW-1:0] acc;

  logic signed [XW-1:0] prod_ws;
  logic signed [XW-1:0] prod_os;
  logic signed [XW-1:0] psum_in;
  logic signed [XW-1:0] ws_sum;
  logic signed [XW-1:0] os_sum;
  logic                 mac_os;

  // Activation is unsigned: widen with zeros so it stays non-negative as signed.
  function automatic logic signed [XW-1:0] widen_act(input logic [BW-1:0] a);
    return {{(XW-BW){1'b0}}, a};
  endfunction

  function automatic logic signed [XW-1:0] widen_w(input logic [BW-1:0] w);
    return {{(XW-BW){w[BW-1]}}, w};
  endfunction

  function automatic logic signed [XW-1:0] mul(input logic [BW-1:0] a,
                                               input logic [BW-1:0] w);
    return widen_act(a) * widen_w(w);
  endfunction

  // The guard bit disagreeing with the PSUM_BW sign bit means the value left
  // the signed PSUM_BW range; only meaningful when saturation is enabled.
  function automatic logic overflow(input logic signed [XW-1:0] v);
    return (SAT != 0) && (v[XW-1] != v[XW-2]);
  endfunction

  // Clamp to the signed PSUM_BW range when SAT is set; otherwise plain
  // truncation gives modulo-2^PSUM_BW wrap.
  function automatic logic signed [PSUM_BW-1:0] saturate(input logic signed [XW-1:0] v);
    if (overflow(v)) begin
      return v[XW-1] ? PSUM_MIN : PSUM_MAX;
    end
    return v[PSUM_BW-1:0];
  endfunction

  assign prod_ws = mul(in_w_act, active_w);
  assign prod_os = mul(in_w_act, in_n_w);
  assign psum_in = in_n_psum_valid ? {in_n_psum[PSUM_BW-1], in_n_psum} : '0;
  assign ws_sum  = psum_in + prod_ws;
  assign os_sum  = {acc[PSUM_BW-1], acc} + prod_os;
  assign mac_os  = in_w_valid && in_n_w_valid;

  assign state = state_q;

  // Next-state logic: halt overrides everything, cfg only leaves IDLE.
  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (cfg_valid) state_d = cfg_mode ? WS_RUN : OS_RUN;
        WS_RUN:   state_d = WS_RUN;
        OS_RUN:   if (drain) state_d = OS_DRAIN;
        OS_DRAIN: if (!drain) state_d = OS_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Weight registers, accumulator and sticky saturation flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_w <= '0;
      active_w <= '0;
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (!halt) begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            shadow_w <= '0;
            active_w <= '0;
            acc      <= '0;
            sat_flag <= 1'b0;
          end
        end
        WS_RUN: begin
          // The swap captures the shadow value from before this cycle's load,
          // and this cycle's MAC still sees the old active weight.
          if (in_n_w_valid) shadow_w <= in_n_w;
          if (w_swap) active_w <= shadow_w;
          if (in_w_valid && overflow(ws_sum)) sat_flag <= 1'b1;
        end
        OS_RUN: begin
          if (drain) begin
            acc <= '0;
          end else if (mac_os) begin
            acc <= saturate(os_sum);
          end
          if (mac_os && overflow(os_sum)) sat_flag <= 1'b1;
        end
        OS_DRAIN: begin
        end
      endcase
    end
  end

  // East/south output registers; every valid is a single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_e_act        <= '0;
      out_e_valid      <= 1'b0;
      out_s_w          <= '0;
      out_s_w_valid    <= 1'b0;
      out_s_psum       <= '0;
      out_s_psum_valid <= 1'b0;
    end else begin
      out_e_valid      <= 1'b0;
      out_s_w_valid    <= 1'b0;
      out_s_psum_valid <= 1'b0;
      if (!halt) begin
        case (state_q)
          IDLE: begin
          end
          WS_RUN: begin
            if (in_n_w_valid) begin
              out_s_w       <= in_n_w;
              out_s_w_valid <= 1'b1;
            end
            if (in_w_valid) begin
              out_e_act        <= in_w_act;
              out_e_valid      <= 1'b1;
              out_s_psum       <= saturate(ws_sum);
              out_s_psum_valid <= 1'b1;
            end
          end
          OS_RUN: begin
            if (in_w_valid) begin
              out_e_act   <= in_w_act;
              out_e_valid <= 1'b1;
            end
            if (in_n_w_valid) begin
              out_s_w       <= in_n_w;
              out_s_w_valid <= 1'b1;
            end
            // The drain cycle's own MAC is folded into the emitted value.
            if (drain) begin
              out_s_psum       <= mac_os ? saturate(os_sum) : acc;
              out_s_psum_valid <= 1'b1;
            end
          end
          OS_DRAIN: begin
            if (in_n_psum_valid) out_s_psum <= in_n_psum;
            out_s_psum_valid <= in_n_psum_valid;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_dualmode_sat.sv
// Bench for pe_dualmode_sat: three instances (16-bit saturating, 10-bit
// saturating, 10-bit wrapping) driven in lockstep, checked every cycle against
// an integer reference model, plus directed value checks.
module tb_pe_dualmode_sat;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid, cfg_mode, halt, drain, w_swap;
  logic [3:0]  in_w_act, in_n_w;
  logic        in_w_valid, in_n_w_valid;
  logic [15:0] in_n_psum;
  logic        in_n_psum_valid;

  logic [3:0]  o_e_act  [3];
  logic        o_e_v    [3];
  logic [3:0]  o_s_w    [3];
  logic        o_s_w_v  [3];
  logic        o_psum_v [3];
  logic [1:0]  o_state  [3];
  logic        o_flag   [3];
  logic [15:0] o_psum0;
  logic [9:0]  o_psum1, o_psum2;

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance.
  int     pbw  [3] = '{16, 10, 10};
  int     psat [3] = '{1, 1, 0};
  int     ms   [3];
  longint msh  [3], mact [3], macc [3];
  longint eea  [3], esw  [3], eps  [3];
  int     eev  [3], eswv [3], epsv [3], eflag [3];

  always #5 clk = ~clk;

  pe_dualmode_sat #(.BW(4), .PSUM_BW(16), .SAT(1)) dut0 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .halt(halt), .drain(drain), .w_swap(w_swap),
    .in_w_act(in_w_act), .in_w_valid(in_w_valid), .in_n_w(in_n_w),
    .in_n_w_valid(in_n_w_valid), .in_n_psum(in_n_psum), .in_n_psum_valid(in_n_psum_valid),
    .out_e_act(o_e_act[0]), .out_e_valid(o_e_v[0]), .out_s_w(o_s_w[0]),
    .out_s_w_valid(o_s_w_v[0]), .out_s_psum(o_psum0), .out_s_psum_valid(o_psum_v[0]),
    .state(o_state[0]), .sat_flag(o_flag[0]));

  pe_dualmode_sat #(.BW(4), .PSUM_BW(10), .SAT(1)) dut1 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .halt(halt), .drain(drain), .w_swap(w_swap),
    .in_w_act(in_w_act), .in_w_valid(in_w_valid), .in_n_w(in_n_w),
    .in_n_w_valid(in_n_w_valid), .in_n_psum(in_n_psum[9:0]), .in_n_psum_valid(in_n_psum_valid),
    .out_e_act(o_e_act[1]), .out_e_valid(o_e_v[1]), .out_s_w(o_s_w[1]),
    .out_s_w_valid(o_s_w_v[1]), .out_s_psum(o_psum1), .out_s_psum_valid(o_psum_v[1]),
    .state(o_state[1]), .sat_flag(o_flag[1]));

  pe_dualmode_sat #(.BW(4), .PSUM_BW(10), .SAT(0)) dut2 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .halt(halt), .drain(drain), .w_swap(w_swap),
    .in_w_act(in_w_act), .in_w_valid(in_w_valid), .in_n_w(in_n_w),
    .in_n_w_valid(in_n_w_valid), .in_n_psum(in_n_psum[9:0]), .in_n_psum_valid(in_n_psum_valid),
    .out_e_act(o_e_act[2]), .out_e_valid(o_e_v[2]), .out_s_w(o_s_w[2]),
    .out_s_w_valid(o_s_w_v[2]), .out_s_psum(o_psum2), .out_s_psum_valid(o_psum_v[2]),
    .state(o_state[2]), .sat_flag(o_flag[2]));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint obs_psum(input int k);
    if (k == 0) return longint'($signed(o_psum0));
    if (k == 1) return longint'($signed(o_psum1));
    return longint'($signed(o_psum2));
  endfunction

  // Two's complement wrap of v into a pbw[k]-bit signed range.
  function automatic longint wrap(input longint v, input int k);
    longint m;
    m = longint'(1) << pbw[k];
    v = v % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  function automatic longint fit(input longint v, input int k, output bit o);
    longint hi, lo;
    hi = (longint'(1) << (pbw[k] - 1)) - 1;
    lo = -hi - 1;
    o = 1'b0;
    if (psat[k] == 0) return wrap(v, k);
    if (v > hi) begin o = 1'b1; return hi; end
    if (v < lo) begin o = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ms[k] = 0; msh[k] = 0; mact[k] = 0; macc[k] = 0;
      eea[k] = 0; esw[k] = 0; eps[k] = 0;
      eev[k] = 0; eswv[k] = 0; epsv[k] = 0; eflag[k] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_eval();
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      longint a, w, pin, s, nacc;
      bit o;
      int ns;
      a   = longint'(in_w_act);
      w   = longint'(in_n_w);
      if (w > 7) w -= 16;
      pin = wrap(longint'(in_n_psum), k);
      eev[k] = 0; eswv[k] = 0; epsv[k] = 0;
      ns = ms[k];
      if (halt) begin
        ns = 0;
      end else begin
        case (ms[k])
          0: if (cfg_valid) begin
               msh[k] = 0; mact[k] = 0; macc[k] = 0; eflag[k] = 0;
               ns = cfg_mode ? 1 : 2;
             end
          1: begin
               if (in_w_valid) begin
                 s = (in_n_psum_valid ? pin : 0) + a * mact[k];
                 eps[k] = fit(s, k, o);
                 if (o) eflag[k] = 1;
                 epsv[k] = 1; eea[k] = a; eev[k] = 1;
               end
               if (w_swap) mact[k] = msh[k];
               if (in_n_w_valid) begin
                 msh[k] = w; esw[k] = longint'(in_n_w); eswv[k] = 1;
               end
             end
          2: begin
               nacc = macc[k];
               if (in_w_valid) begin eea[k] = a; eev[k] = 1; end
               if (in_n_w_valid) begin esw[k] = longint'(in_n_w); eswv[k] = 1; end
               if (in_w_valid && in_n_w_valid) begin
                 nacc = fit(macc[k] + a * w, k, o);
                 if (o) eflag[k] = 1;
               end
               if (drain) begin
                 eps[k] = nacc; epsv[k] = 1; macc[k] = 0; ns = 3;
               end else begin
                 macc[k] = nacc;
               end
             end
          default: begin
               if (in_n_psum_valid) eps[k] = pin;
               epsv[k] = in_n_psum_valid ? 1 : 0;
               if (!drain) ns = 2;
             end
        endcase
      end
      ms[k] = ns;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s d%0d state", tag, k), longint'(o_state[k]), longint'(ms[k]));
      chk($sformatf("%s d%0d e_act", tag, k), longint'(o_e_act[k]), eea[k]);
      chk($sformatf("%s d%0d e_valid", tag, k), longint'(o_e_v[k]), longint'(eev[k]));
      chk($sformatf("%s d%0d s_w", tag, k), longint'(o_s_w[k]), esw[k]);
      chk($sformatf("%s d%0d s_w_valid", tag, k), longint'(o_s_w_v[k]), longint'(eswv[k]));
      chk($sformatf("%s d%0d psum", tag, k), obs_psum(k), eps[k]);
      chk($sformatf("%s d%0d psum_valid", tag, k), longint'(o_psum_v[k]), longint'(epsv[k]));
      chk($sformatf("%s d%0d sat_flag", tag, k), longint'(o_flag[k]), longint'(eflag[k]));
    end
  endtask

  task automatic step(input string tag);
    model_eval();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clear_in();
    cfg_valid = 0; cfg_mode = 0; halt = 0; drain = 0; w_swap = 0;
    in_w_act = 0; in_w_valid = 0; in_n_w = 0; in_n_w_valid = 0;
    in_n_psum = 0; in_n_psum_valid = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    model_reset();
    step("rst0");
    step("rst1");
    reset = 1'b0;
    step("rst_state");
    chk("reset state", longint'(o_state[0]), 0);

    // T1: weight -3 shifted in, swapped, act 5 + psum 10 -> -5
    cfg_valid = 1; cfg_mode = 1; step("t1_cfg"); clear_in();
    chk("T1 state WS", longint'(o_state[0]), 1);
    in_n_w = 4'hD; in_n_w_valid = 1; step("t1_load"); clear_in();
    chk("T1 shift out", longint'(o_s_w[0]), 13);
    w_swap = 1; step("t1_swap"); clear_in();
    in_w_act = 5; in_w_valid = 1; in_n_psum = 16'd10; in_n_psum_valid = 1;
    step("t1_mac"); clear_in();
    chk("T1 psum", obs_psum(0), -5);

    // T2: active 2, shadow 7, swap racing a MAC
    in_n_w = 4'd2; in_n_w_valid = 1; step("t2_l2"); clear_in();
    w_swap = 1; step("t2_s2"); clear_in();
    in_n_w = 4'd7; in_n_w_valid = 1; step("t2_l7"); clear_in();
    w_swap = 1; in_w_act = 3; in_w_valid = 1; step("t2_race"); clear_in();
    chk("T2 old weight", obs_psum(0), 6);
    in_w_act = 3; in_w_valid = 1; step("t2_new"); clear_in();
    chk("T2 new weight", obs_psum(0), 21);

    // cfg in WS ignored, then halt
    cfg_valid = 1; cfg_mode = 0; step("t5_cfg_ign"); clear_in();
    chk("cfg ignored in WS", longint'(o_state[0]), 1);
    halt = 1; step("halt_ws"); clear_in();

    // T3: OS accumulate, drain, pass-through
    cfg_valid = 1; cfg_mode = 0; step("t3_cfg"); clear_in();
    in_w_act = 15; in_n_w = 4'd7; in_w_valid = 1; in_n_w_valid = 1; step("t3_p1");
    step("t3_p2");
    in_w_act = 1; in_n_w = 4'h8; step("t3_p3"); clear_in();
    drain = 1; step("t3_drain");
    chk("T3 drained acc", obs_psum(0), 202);
    chk("T3 drain state", longint'(o_state[0]), 3);
    in_n_psum = 16'd9; in_n_psum_valid = 1; in_w_valid = 1; in_n_w_valid = 1;
    step("t3_pass"); clear_in();
    chk("T3 pass psum", obs_psum(0), 9);
    chk("T3 act not forwarded", longint'(o_e_v[0]), 0);
    step("t3_back");
    chk("T3 back to OS", longint'(o_state[0]), 2);

    // T4: saturation vs wrap at PSUM_BW=10
    halt = 1; step("t4_halt"); clear_in();
    cfg_valid = 1; cfg_mode = 0; step("t4_cfg"); clear_in();
    for (int i = 0; i < 5; i++) begin
      in_w_act = 15; in_n_w = 4'd7; in_w_valid = 1; in_n_w_valid = 1;
      step("t4_mac");
    end
    clear_in();
    drain = 1; step("t4_drain"); clear_in();
    chk("T4 wide acc", obs_psum(0), 525);
    chk("T4 sat acc", obs_psum(1), 511);
    chk("T4 sat flag", longint'(o_flag[1]), 1);
    chk("T4 wrap acc", obs_psum(2), -499);
    chk("T4 wrap flag", longint'(o_flag[2]), 0);

    // T5: halt during OS_DRAIN with traffic
    in_w_act = 3; in_n_w = 4'd2; in_w_valid = 1; in_n_w_valid = 1; step("t5_mac"); clear_in();
    drain = 1; step("t5_drain");
    halt = 1; drain = 1; in_w_valid = 1; in_n_w_valid = 1; in_n_psum_valid = 1;
    in_n_psum = 16'd44; step("t5_halt"); clear_in();
    chk("T5 state idle", longint'(o_state[0]), 0);
    chk("T5 psum valid", longint'(o_psum_v[0]), 0);
    chk("T5 e valid", longint'(o_e_v[0]), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      halt            = ($urandom_range(0, 31) == 0);
      cfg_valid       = ($urandom_range(0, 3) == 0);
      cfg_mode        = 1'($urandom_range(0, 1));
      drain           = ($urandom_range(0, 3) == 0);
      w_swap          = ($urandom_range(0, 3) == 0);
      in_w_act        = 4'($urandom_range(0, 15));
      in_n_w          = 4'($urandom_range(0, 15));
      in_w_valid      = 1'($urandom_range(0, 1));
      in_n_w_valid    = 1'($urandom_range(0, 1));
      in_n_psum_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       in_n_psum = 16'h7FC0 | 16'($urandom_range(0, 63));
        1:       in_n_psum = 16'h8000 | 16'($urandom_range(0, 63));
        default: in_n_psum = 16'($urandom_range(0, 65535));
      endcase
      step("rand");
    end
    clear_in();

    // T6: asynchronous reset mid-WS with traffic
    halt = 1; step("t6_halt"); clear_in();
    cfg_valid = 1; cfg_mode = 1; step("t6_cfg"); clear_in();
    in_w_act = 9; in_w_valid = 1; in_n_w = 4'd5; in_n_w_valid = 1;
    in_n_psum = 16'd100; in_n_psum_valid = 1;
    step("t6_traffic");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    chk("T6 state idle", longint'(o_state[0]), 0);
    chk("T6 psum zero", obs_psum(0), 0);
    #1 reset = 1'b0;
    step("t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
